// File: rtl/controle_busca_pkg.sv
// -----------------------------------------------------------------------------
// controle_busca_pkg
// Shared definitions for the instruction fetch controller: state encoding,
// datapath widths, the end of the addressable instruction window and the
// address checks used on redirects and fetch attempts.
// -----------------------------------------------------------------------------
package controle_busca_pkg;

    localparam int PC_W  = 32;    // width of the program counter / byte address
    localparam int IDX_W = 8;     // width of the instruction memory word index

    // First byte address past the instruction memory (256 words of 4 bytes).
    localparam logic [PC_W-1:0] LIMITE_END = 32'h0000_0400;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        BUSCANDO = 2'd1,
        ERRO     = 2'd2
    } estado_t;

    // Address lies outside the instruction memory window.
    function automatic logic fora_limite(input logic [PC_W-1:0] endereco);
        return (endereco >= LIMITE_END);
    endfunction

    // A redirect target must be word aligned and inside the window.
    function automatic logic alvo_invalido(input logic [PC_W-1:0] alvo);
        return (alvo[1:0] != 2'b00) || fora_limite(alvo);
    endfunction

endpackage

// File: rtl/controle_busca_if.sv
// -----------------------------------------------------------------------------
// controle_busca_if
// Valid/ready instruction channel between the fetch controller and the
// decode stage.
//   instr_valida : fetch -> decode, instruction word on the channel is valid
//   instr_pronta : decode -> fetch, decode accepts the instruction this cycle
//   instr_dado   : fetch -> decode, instruction word
//   instr_pc     : fetch -> decode, byte address of instr_dado
// modport master : fetch side (controle_busca)
// modport slave  : decode side
// -----------------------------------------------------------------------------
interface controle_busca_if;
    import controle_busca_pkg::*;

    logic            instr_valida;
    logic            instr_pronta;
    logic [PC_W-1:0] instr_dado;
    logic [PC_W-1:0] instr_pc;

    modport master (
        output instr_valida,
        output instr_dado,
        output instr_pc,
        input  instr_pronta
    );

    modport slave (
        input  instr_valida,
        input  instr_dado,
        input  instr_pc,
        output instr_pronta
    );

endinterface

// File: rtl/controle_busca.sv
// -----------------------------------------------------------------------------
// controle_busca
// Instruction fetch controller. Walks the PC through a 256-word instruction
// memory that sits beside this block (combinational read), registers each
// word with its byte address and offers it to decode over a valid/ready
// channel at up to one instruction per cycle. Accepts single-cycle redirects
// and locks into an error state on a bad redirect target or when the PC runs
// off the end of the memory; only reset leaves the error state.
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   habilitar      : level, 1 permits fetching
//   desvio_valido  : one-cycle redirect request
//   desvio_alvo    : redirect target byte address
//   endereco_mem   : word index to the instruction memory (pc[9:2])
//   dado_mem       : read data from the instruction memory
//   saida          : instruction channel to decode (master modport)
//   contador_instr : number of instructions accepted by decode (wraps)
//   erro           : high while in the error state
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// OCIOSO   | fetching disabled; a held instruction may still drain
// BUSCANDO | fetching one word per cycle whenever the output slot is free
// ERRO     | bad redirect or PC out of range; frozen until reset
// -----------------------------------------------------------------------------
module controle_busca
    import controle_busca_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    habilitar,
    input  logic                    desvio_valido,
    input  logic [PC_W-1:0]         desvio_alvo,
    output logic [IDX_W-1:0]        endereco_mem,
    input  logic [PC_W-1:0]         dado_mem,
    controle_busca_if.master        saida,
    output logic [15:0]             contador_instr,
    output logic                    erro
);

    estado_t         estado, estado_prox;
    logic [PC_W-1:0] pc, pc_prox;
    logic            valida_q, valida_prox;
    logic [PC_W-1:0] dado_q, dado_prox;
    logic [PC_W-1:0] ipc_q, ipc_prox;
    logic [15:0]     contador_q, contador_prox;
    logic            handshake;
    logic            slot_livre;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= OCIOSO;
            pc         <= PC_RESET;
            valida_q   <= 1'b0;
            dado_q     <= '0;
            ipc_q      <= '0;
            contador_q <= '0;
        end else begin
            estado     <= estado_prox;
            pc         <= pc_prox;
            valida_q   <= valida_prox;
            dado_q     <= dado_prox;
            ipc_q      <= ipc_prox;
            contador_q <= contador_prox;
        end
    end

    assign handshake  = valida_q && saida.instr_pronta;
    assign slot_livre = !valida_q || saida.instr_pronta;

    // Next-state and datapath update.
    always_comb begin
        estado_prox   = estado;
        pc_prox       = pc;
        valida_prox   = valida_q;
        dado_prox     = dado_q;
        ipc_prox      = ipc_q;
        contador_prox = contador_q;

        // Accepted instructions are counted in every state, and an accepted
        // instruction leaves the slot unless something new replaces it below.
        if (handshake) begin
            contador_prox = contador_q + 16'd1;
            valida_prox   = 1'b0;
        end

        case (estado)
            ERRO: begin
                // Frozen: redirects and fetches are ignored, only draining.
            end

            default: begin
                estado_prox = habilitar ? BUSCANDO : OCIOSO;

                if (desvio_valido) begin
                    // A rejected redirect keeps the PC where it was.
                    if (alvo_invalido(desvio_alvo)) begin
                        estado_prox = ERRO;
                    end else begin
                        pc_prox     = desvio_alvo;
                        valida_prox = 1'b0;
                    end
                end else if ((estado == BUSCANDO) && slot_livre) begin
                    if (fora_limite(pc)) begin
                        // Ran past the last word: nothing is loaded.
                        estado_prox = ERRO;
                    end else begin
                        dado_prox   = dado_mem;
                        ipc_prox    = pc;
                        valida_prox = 1'b1;
                        pc_prox     = pc + 32'd4;
                    end
                end
            end
        endcase
    end

    assign endereco_mem       = pc[IDX_W+1:2];
    assign saida.instr_valida = valida_q;
    assign saida.instr_dado   = dado_q;
    assign saida.instr_pc     = ipc_q;
    assign contador_instr     = contador_q;
    assign erro               = (estado == ERRO);

endmodule

// File: tb/tb_controle_busca.sv
// -----------------------------------------------------------------------------
// tb_controle_busca
// Self-checking bench for controle_busca: directed table of vectors, directed
// error/reset/wrap sequences, and randomized traffic compared against a
// behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_controle_busca;

    logic        clk;
    logic        rst_n;
    logic        habilitar;
    logic        desvio_valido;
    logic [31:0] desvio_alvo;
    logic [7:0]  endereco_mem;
    logic [31:0] dado_mem;
    logic [15:0] contador_instr;
    logic        erro;
    logic        pronta;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_err    = 0;

    controle_busca_if bus ();

    assign bus.instr_pronta = pronta;
    assign dado_mem         = mem[endereco_mem];

    controle_busca dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .habilitar      (habilitar),
        .desvio_valido  (desvio_valido),
        .desvio_alvo    (desvio_alvo),
        .endereco_mem   (endereco_mem),
        .dado_mem       (dado_mem),
        .saida          (bus.master),
        .contador_instr (contador_instr),
        .erro           (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // m_mode: 0 idle, 1 fetching, 2 error
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_dado;
    logic [31:0] m_ipc;
    logic [15:0] m_cnt;

    logic        t_hs;
    logic        t_bad;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_pc    <= 32'h0;
            m_valid <= 1'b0;
            m_dado  <= 32'h0;
            m_ipc   <= 32'h0;
            m_cnt   <= 16'h0;
        end else begin
            t_hs  = m_valid && pronta;
            t_bad = (desvio_alvo % 4 != 0) || (desvio_alvo >= 32'd1024);
            if (t_hs) begin
                m_cnt   <= 16'((int'(m_cnt) + 1) % 65536);
                m_valid <= 1'b0;
            end
            if (m_mode != 2) begin
                m_mode <= habilitar ? 1 : 0;
                if (desvio_valido) begin
                    if (t_bad) m_mode <= 2;
                    else begin
                        m_pc    <= desvio_alvo;
                        m_valid <= 1'b0;
                    end
                end else if (m_mode == 1 && (!m_valid || pronta)) begin
                    if (m_pc >= 32'd1024) begin
                        m_mode  <= 2;
                        m_valid <= 1'b0;
                    end else begin
                        m_dado  <= mem[m_pc / 4];
                        m_ipc   <= m_pc;
                        m_valid <= 1'b1;
                        m_pc    <= m_pc + 4;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nome, input logic [31:0] obtido,
                         input logic [31:0] esperado);
        n_checks++;
        if (obtido !== esperado) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nome, obtido, esperado, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " valida"}, 32'(bus.instr_valida), 32'(m_valid));
        check({tag, " cnt"},    32'(contador_instr),   32'(m_cnt));
        check({tag, " end"},    32'(endereco_mem),     32'(m_pc[9:2]));
        check({tag, " erro"},   32'(erro),             32'(m_mode == 2));
        if (m_valid) begin
            check({tag, " dado"}, bus.instr_dado, m_dado);
            check({tag, " ipc"},  bus.instr_pc,   m_ipc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        habilitar     = 1'b0;
        desvio_valido = 1'b0;
        desvio_alvo   = 32'h0;
        pronta        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        hab;
        logic        dv;
        logic        pr;
        logic [31:0] alvo;
        logic        ev;
        logic [31:0] ed;
        logic [31:0] ep;
        logic [7:0]  ee;
        logic [15:0] ec;
        logic        er;
    } vec_t;

    vec_t tab [17];
    logic [31:0] maus [4];

    initial begin
        rst_n         = 1'b1;
        habilitar     = 1'b0;
        desvio_valido = 1'b0;
        desvio_alvo   = 32'h0;
        pronta        = 1'b0;

        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[0]  = 32'h001101B3;
        mem[1]  = 32'h0000000C;
        mem[2]  = 32'h00005FD3;
        mem[3]  = 32'h00A00093;
        mem[16] = 32'h12345678;
        mem[17] = 32'h9ABCDEF0;

        //            hab dv  pr  alvo        ev  dado          ipc    end    cnt  er
        tab[0]  = '{1'b1,1'b0,1'b1,32'h0,  1'b0,32'h0,        32'h0, 8'h00, 16'd0,1'b0};
        tab[1]  = '{1'b1,1'b0,1'b1,32'h0,  1'b1,32'h001101B3, 32'h0, 8'h01, 16'd0,1'b0};
        tab[2]  = '{1'b1,1'b0,1'b1,32'h0,  1'b1,32'h0000000C, 32'h4, 8'h02, 16'd1,1'b0};
        tab[3]  = '{1'b1,1'b0,1'b1,32'h0,  1'b1,32'h00005FD3, 32'h8, 8'h03, 16'd2,1'b0};
        tab[4]  = '{1'b1,1'b0,1'b0,32'h0,  1'b1,32'h00005FD3, 32'h8, 8'h03, 16'd2,1'b0};
        tab[5]  = '{1'b1,1'b0,1'b0,32'h0,  1'b1,32'h00005FD3, 32'h8, 8'h03, 16'd2,1'b0};
        tab[6]  = '{1'b1,1'b0,1'b0,32'h0,  1'b1,32'h00005FD3, 32'h8, 8'h03, 16'd2,1'b0};
        tab[7]  = '{1'b1,1'b0,1'b1,32'h0,  1'b1,32'h00A00093, 32'hC, 8'h04, 16'd3,1'b0};
        tab[8]  = '{1'b1,1'b1,1'b1,32'h40, 1'b0,32'h0,        32'h0, 8'h10, 16'd4,1'b0};
        tab[9]  = '{1'b1,1'b0,1'b1,32'h0,  1'b1,32'h12345678, 32'h40,8'h11, 16'd4,1'b0};
        tab[10] = '{1'b1,1'b0,1'b1,32'h0,  1'b1,32'h9ABCDEF0, 32'h44,8'h12, 16'd5,1'b0};
        tab[11] = '{1'b0,1'b0,1'b0,32'h0,  1'b1,32'h9ABCDEF0, 32'h44,8'h12, 16'd5,1'b0};
        tab[12] = '{1'b0,1'b0,1'b1,32'h0,  1'b0,32'h0,        32'h0, 8'h12, 16'd6,1'b0};
        tab[13] = '{1'b0,1'b0,1'b1,32'h0,  1'b0,32'h0,        32'h0, 8'h12, 16'd6,1'b0};
        tab[14] = '{1'b0,1'b1,1'b0,32'h8,  1'b0,32'h0,        32'h0, 8'h02, 16'd6,1'b0};
        tab[15] = '{1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,        32'h0, 8'h02, 16'd6,1'b0};
        tab[16] = '{1'b1,1'b0,1'b1,32'h0,  1'b1,32'h00005FD3, 32'h8, 8'h03, 16'd6,1'b0};

        // ---------------- reset values ----------------
        do_reset();
        #1;
        check("rst valida", 32'(bus.instr_valida), 32'h0);
        check("rst dado",   bus.instr_dado,        32'h0);
        check("rst ipc",    bus.instr_pc,          32'h0);
        check("rst cnt",    32'(contador_instr),   32'h0);
        check("rst erro",   32'(erro),             32'h0);
        check("rst end",    32'(endereco_mem),     32'h0);

        // ---------------- directed table ----------------
        for (int i = 0; i < 17; i++) begin
            habilitar     = tab[i].hab;
            desvio_valido = tab[i].dv;
            desvio_alvo   = tab[i].alvo;
            pronta        = tab[i].pr;
            step();
            check($sformatf("tab%0d valida", i), 32'(bus.instr_valida), 32'(tab[i].ev));
            check($sformatf("tab%0d end", i),    32'(endereco_mem),     32'(tab[i].ee));
            check($sformatf("tab%0d cnt", i),    32'(contador_instr),   32'(tab[i].ec));
            check($sformatf("tab%0d erro", i),   32'(erro),             32'(tab[i].er));
            if (tab[i].ev) begin
                check($sformatf("tab%0d dado", i), bus.instr_dado, tab[i].ed);
                check($sformatf("tab%0d ipc", i),  bus.instr_pc,   tab[i].ep);
            end
        end

        // Misaligned redirect mid-stream: error, PC and held word unchanged.
        desvio_valido = 1'b1; desvio_alvo = 32'h42; pronta = 1'b0;
        step();
        check("bad42 erro",  32'(erro),             32'h1);
        check("bad42 end",   32'(endereco_mem),     32'h3);
        check("bad42 ipc",   bus.instr_pc,          32'h8);
        check("bad42 valid", 32'(bus.instr_valida), 32'h1);
        // In ERRO the held word drains, nothing new is fetched.
        desvio_valido = 1'b0; pronta = 1'b1;
        step();
        check("erro drain valid", 32'(bus.instr_valida), 32'h0);
        check("erro drain cnt",   32'(contador_instr),   32'd7);
        check("erro nofetch end", 32'(endereco_mem),     32'h3);
        // Redirects ignored in ERRO.
        desvio_valido = 1'b1; desvio_alvo = 32'h10;
        step();
        desvio_valido = 1'b0;
        check("erro ignore dv end", 32'(endereco_mem), 32'h3);
        check("erro sticky",        32'(erro),         32'h1);

        // ---------------- other bad targets ----------------
        maus[0] = 32'h0000_0042;
        maus[1] = 32'h0000_0001;
        maus[2] = 32'h0000_0400;
        maus[3] = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            desvio_valido = 1'b1; desvio_alvo = 32'h20;
            step();
            desvio_alvo = maus[i];
            step();
            desvio_valido = 1'b0;
            check($sformatf("bad%0d erro", i), 32'(erro),         32'h1);
            check($sformatf("bad%0d end", i),  32'(endereco_mem), 32'h08);
        end

        // ---------------- run off the end of memory ----------------
        do_reset();
        desvio_valido = 1'b1; desvio_alvo = 32'h3F8; pronta = 1'b1;
        step();
        check("fim end", 32'(endereco_mem), 32'hFE);
        desvio_valido = 1'b0; habilitar = 1'b1;
        step();
        check("fim enter valid", 32'(bus.instr_valida), 32'h0);
        step();
        check("fim w254 ipc",  bus.instr_pc,   32'h3F8);
        check("fim w254 dado", bus.instr_dado, mem[254]);
        check("fim w254 erro", 32'(erro),      32'h0);
        step();
        check("fim w255 ipc",  bus.instr_pc,   32'h3FC);
        check("fim w255 dado", bus.instr_dado, mem[255]);
        check("fim w255 erro", 32'(erro),      32'h0);
        step();
        check("fim 400 erro",  32'(erro),             32'h1);
        check("fim 400 valid", 32'(bus.instr_valida), 32'h0);
        check("fim 400 cnt",   32'(contador_instr),   32'd2);

        // ---------------- asynchronous reset mid-stream ----------------
        do_reset();
        habilitar = 1'b1; pronta = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("pre-rst valid", 32'(bus.instr_valida), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async valida", 32'(bus.instr_valida), 32'h0);
        check("async dado",   bus.instr_dado,        32'h0);
        check("async ipc",    bus.instr_pc,          32'h0);
        check("async cnt",    32'(contador_instr),   32'h0);
        check("async erro",   32'(erro),             32'h0);
        check("async end",    32'(endereco_mem),     32'h0);
        rst_n = 1'b1;

        // ---------------- randomized traffic vs model ----------------
        for (int blk = 0; blk < 8; blk++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                habilitar     = ($urandom_range(0, 7) != 0);
                pronta        = ($urandom_range(0, 3) != 0);
                desvio_valido = ($urandom_range(0, 15) == 0);
                case ($urandom_range(0, 9))
                    8:       desvio_alvo = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
                    9:       desvio_alvo = $urandom() | 32'h400;
                    default: desvio_alvo = 32'({$urandom_range(0, 255), 2'b00});
                endcase
                step();
                check_model("rnd");
                if ($urandom_range(0, 199) == 0) begin
                    rst_n = 1'b0;
                    #1;
                    check_model("rnd rst");
                    rst_n = 1'b1;
                end
            end
        end

        // ---------------- counter wrap ----------------
        do_reset();
        habilitar = 1'b1; pronta = 1'b1; desvio_alvo = 32'h0;
        for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++) begin
            desvio_valido = (m_pc == 32'h3F0);
            step();
        end
        desvio_valido = 1'b0;
        check("wrap ffff", 32'(contador_instr), 32'h0000FFFF);
        for (int k = 0; k < 4 && m_cnt != 16'h0000; k++) step();
        check("wrap zero", 32'(contador_instr), 32'h00000000);
        check("wrap erro", 32'(erro),           32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
